// File: rtl/video_pkg.sv
// Shared video timing constants and ball FSM state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_pkg;

  localparam int POS_W         = 10;
  localparam int H_DISPLAY_DEF = 256;
  localparam int V_DISPLAY_DEF = 240;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    STEP_X = 2'd1,
    STEP_Y = 2'd2,
    COMMIT = 2'd3
  } state_t;

endpackage

// File: rtl/axis_bounce.sv
// One-axis ball step with wall reflection; shared by X and Y.
// Latency: purely combinational, the caller registers the results.
// Backpressure: none.
module axis_bounce
  import video_pkg::*;
#(
  parameter int MAX   = 252,
  parameter int SPEED = 2
) (
  input  logic [POS_W-1:0] pos,
  input  logic             dir,
  output logic [POS_W-1:0] next_pos,
  output logic             next_dir,
  output logic             hit
);

  // One extra bit so pos + SPEED can never wrap before the compare.
  localparam int W1 = POS_W + 1;
  localparam logic [W1-1:0] MAX_W = W1'(MAX);
  localparam logic [W1-1:0] SPD_W = W1'(SPEED);

  logic [W1-1:0] pos_w;
  logic [W1-1:0] sum;

  assign pos_w = {1'b0, pos};
  assign sum   = pos_w + SPD_W;

  // Landing exactly on a wall counts as a hit and reverses direction.
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    hit      = 1'b0;
    if (!dir) begin
      if (sum >= MAX_W) begin
        next_pos = MAX_W[POS_W-1:0];
        next_dir = 1'b1;
        hit      = 1'b1;
      end else begin
        next_pos = sum[POS_W-1:0];
      end
    end else begin
      if (pos_w <= SPD_W) begin
        next_pos = '0;
        next_dir = 1'b0;
        hit      = 1'b1;
      end else begin
        next_pos = pos - SPD_W[POS_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Per-frame ball position generator: steps X then Y on each vsync rise, reflecting off edges.
// Latency: rise sampled in cycle N -> X updates end of N+1, Y end of N+2, pulses during N+3.
// Backpressure: none; rises outside WAIT are dropped. Optional BALL_MOTION_PAUSE_EN adds i_pause.
module ball_motion
  import video_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int BALL_SIZE = 4,
  parameter int X_INIT    = 128,
  parameter int Y_INIT    = 128,
  parameter int X_SPEED   = 2,
  parameter int Y_SPEED   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             vsync,
`ifdef BALL_MOTION_PAUSE_EN
  input  logic             i_pause,
`endif
  output logic [POS_W-1:0] o_ball_x,
  output logic [POS_W-1:0] o_ball_y,
  output logic             o_dir_x,
  output logic             o_dir_y,
  output logic             o_hit_x,
  output logic             o_hit_y,
  output logic             o_frame_done
);

  state_t           state_q, state_d;
  logic             vsync_q;
  logic             rise;
  logic             pause_req;
  logic             hit_x_q, hit_y_q, hit_x_d, hit_y_d;
  logic [POS_W-1:0] x_d, y_d;
  logic             dir_x_d, dir_y_d;
  logic [POS_W-1:0] x_step, y_step;
  logic             dir_x_step, dir_y_step;
  logic             hit_x_step, hit_y_step;

  assign rise = vsync & ~vsync_q;

`ifdef BALL_MOTION_PAUSE_EN
  assign pause_req = i_pause;
`else
  assign pause_req = 1'b0;
`endif

  axis_bounce #(.MAX(H_DISPLAY - BALL_SIZE), .SPEED(X_SPEED)) u_bounce_x (
    .pos      (o_ball_x),
    .dir      (o_dir_x),
    .next_pos (x_step),
    .next_dir (dir_x_step),
    .hit      (hit_x_step)
  );

  axis_bounce #(.MAX(V_DISPLAY - BALL_SIZE), .SPEED(Y_SPEED)) u_bounce_y (
    .pos      (o_ball_y),
    .dir      (o_dir_y),
    .next_pos (y_step),
    .next_dir (dir_y_step),
    .hit      (hit_y_step)
  );

  // Next-state and next-position selection; each axis commits in its own step state.
  always_comb begin
    state_d = state_q;
    x_d     = o_ball_x;
    y_d     = o_ball_y;
    dir_x_d = o_dir_x;
    dir_y_d = o_dir_y;
    hit_x_d = hit_x_q;
    hit_y_d = hit_y_q;
    case (state_q)
      WAIT: begin
        if (rise) begin
          hit_x_d = 1'b0;
          hit_y_d = 1'b0;
          state_d = pause_req ? COMMIT : STEP_X;
        end
      end
      STEP_X: begin
        x_d     = x_step;
        dir_x_d = dir_x_step;
        hit_x_d = hit_x_step;
        state_d = STEP_Y;
      end
      STEP_Y: begin
        y_d     = y_step;
        dir_y_d = dir_y_step;
        hit_y_d = hit_y_step;
        state_d = COMMIT;
      end
      COMMIT:  state_d = WAIT;
      default: state_d = WAIT;
    endcase
  end

  // State, position and registered pulses; pulses are high exactly while in COMMIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT;
      vsync_q      <= 1'b1;
      o_ball_x     <= POS_W'(X_INIT);
      o_ball_y     <= POS_W'(Y_INIT);
      o_dir_x      <= 1'b0;
      o_dir_y      <= 1'b0;
      hit_x_q      <= 1'b0;
      hit_y_q      <= 1'b0;
      o_hit_x      <= 1'b0;
      o_hit_y      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      vsync_q      <= vsync;
      o_ball_x     <= x_d;
      o_ball_y     <= y_d;
      o_dir_x      <= dir_x_d;
      o_dir_y      <= dir_y_d;
      hit_x_q      <= hit_x_d;
      hit_y_q      <= hit_y_d;
      o_frame_done <= (state_d == COMMIT);
      o_hit_x      <= (state_d == COMMIT) & hit_x_d;
      o_hit_y      <= (state_d == COMMIT) & hit_y_d;
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench: two ball_motion instances (centre start, near-corner start) on shared stimulus.
// Latency: checks are cycle-exact, sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_ball_motion;

  logic clk = 1'b0;
  logic reset;
  logic vsync;
`ifdef BALL_MOTION_PAUSE_EN
  logic pause;
`endif

  logic [9:0] x0, y0, x1, y1;
  logic dx0, dy0, hx0, hy0, fd0;
  logic dx1, dy1, hx1, hy1, fd1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ball_motion dut0 (
    .clk(clk), .reset(reset), .vsync(vsync),
`ifdef BALL_MOTION_PAUSE_EN
    .i_pause(pause),
`endif
    .o_ball_x(x0), .o_ball_y(y0), .o_dir_x(dx0), .o_dir_y(dy0),
    .o_hit_x(hx0), .o_hit_y(hy0), .o_frame_done(fd0)
  );

  ball_motion #(.X_INIT(250), .Y_INIT(234)) dut1 (
    .clk(clk), .reset(reset), .vsync(vsync),
`ifdef BALL_MOTION_PAUSE_EN
    .i_pause(pause),
`endif
    .o_ball_x(x1), .o_ball_y(y1), .o_dir_x(dx1), .o_dir_y(dy1),
    .o_hit_x(hx1), .o_hit_y(hy1), .o_frame_done(fd1)
  );

  task automatic check_eq(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full update frame. vsync must be low on entry. When inject is set a
  // second rise is presented while the FSM is in STEP_Y and must be ignored.
  task automatic run_frame(input int ex0, input int ey0,
                           input int ex1, input int ey1,
                           input int ehx1, input int ehy1,
                           input int edx1, input int edy1,
                           input bit inject);
    vsync = 1'b1;
    tick();                                    // N+1: STEP_X
    check_eq("fd0_n1", fd0, 0);
    if (inject) vsync = 1'b0;
    tick();                                    // N+2: X committed
    check_eq("x0_n2", x0, ex0);
    check_eq("dx1_n2", dx1, edx1);
    if (inject) vsync = 1'b1;
    tick();                                    // N+3: COMMIT
    check_eq("fd0_n3", fd0, 1);
    check_eq("fd1_n3", fd1, 1);
    check_eq("x0", x0, ex0);
    check_eq("y0", y0, ey0);
    check_eq("hx0", hx0, 0);
    check_eq("hy0", hy0, 0);
    check_eq("x1", x1, ex1);
    check_eq("y1", y1, ey1);
    check_eq("hx1", hx1, ehx1);
    check_eq("hy1", hy1, ehy1);
    check_eq("dy1", dy1, edy1);
    tick();                                    // N+4: pulses gone
    check_eq("fd0_n4", fd0, 0);
    check_eq("hx1_n4", hx1, 0);
    tick();
    check_eq("fd0_n5", fd0, 0);
    check_eq("x0_hold", x0, ex0);
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    vsync = 1'b1;
`ifdef BALL_MOTION_PAUSE_EN
    pause = 1'b0;
`endif
    tick();
    tick();
    check_eq("rst_x0", x0, 128);
    check_eq("rst_y0", y0, 128);
    check_eq("rst_dx0", dx0, 0);
    check_eq("rst_dy0", dy0, 0);
    check_eq("rst_fd0", fd0, 0);
    check_eq("rst_hx0", hx0, 0);
    check_eq("rst_x1", x1, 250);
    check_eq("rst_y1", y1, 234);

    // vsync already high at reset release must not count as a rise
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("no_rise_fd0", fd0, 0);
      check_eq("no_rise_x0", x0, 128);
    end
    vsync = 1'b0;
    tick();

    // Centre ball steps +2; corner ball hits both walls in the same frame
    run_frame(130, 130, 252, 236, 1, 1, 1, 1, 1'b0);
    // Corner ball moves back away from the walls without a hit
    run_frame(132, 132, 250, 234, 0, 0, 1, 1, 1'b0);
    // Second rise during STEP_Y ignored: exactly one step, one pulse
    run_frame(134, 134, 248, 232, 0, 0, 1, 1, 1'b1);

    // Reset asserted while in STEP_Y
    vsync = 1'b1;
    tick();                                    // STEP_X
    tick();                                    // STEP_Y, X already moved
    check_eq("pre_rst_x0", x0, 136);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_x0", x0, 128);
    check_eq("mid_rst_y0", y0, 128);
    check_eq("mid_rst_dx1", dx1, 0);
    check_eq("mid_rst_dy1", dy1, 0);
    check_eq("mid_rst_fd0", fd0, 0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_fd0", fd0, 0);
    check_eq("post_rst_x1", x1, 250);
    vsync = 1'b0;
    tick();

`ifdef BALL_MOTION_PAUSE_EN
    // Paused frames: WAIT goes straight to COMMIT, position frozen
    pause = 1'b1;
    for (int f = 0; f < 3; f++) begin
      vsync = 1'b1;
      tick();
      check_eq("pause_fd0", fd0, 1);
      check_eq("pause_hx1", hx1, 0);
      check_eq("pause_x0", x0, 128);
      check_eq("pause_y0", y0, 128);
      tick();
      check_eq("pause_fd0_off", fd0, 0);
      vsync = 1'b0;
      tick();
    end
    pause = 1'b0;
`endif

    // Normal update after reset (and after any pause)
    run_frame(130, 130, 252, 236, 1, 1, 1, 1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
